// File: rtl/cgra_rf_pkg.sv
// Shared definitions for the CGRA register-file arbiter.
//   clog2 / ptr_width : pointer width helpers (constant functions)
//   RR_PTR_W          : round-robin pointer width for the default requester count
//   resp_tag_t        : read-response tag {valid, id} carried across the RF read latency
package cgra_rf_pkg;

    localparam int MAX_REQ     = 8;
    localparam int DEF_NUM_REQ = 4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // A pointer always needs at least one bit, even for a single requester.
    function automatic int ptr_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    localparam int RR_PTR_W = ptr_width(DEF_NUM_REQ);
    localparam int TAG_ID_W = ptr_width(MAX_REQ);

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } resp_tag_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req   : request vector
//   start : highest-priority index (must be < N)
//   mask  : requests to ignore
//   found : some unmasked request exists
//   idx   : first unmasked request at or after start, wrapping modulo N
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    input  logic [N-1:0]  mask,
    output logic          found,
    output logic [PW-1:0] idx
);
    logic [N-1:0] elig;
    assign elig = req & ~mask;

    always_comb begin
        int            j;
        logic [PW-1:0] cand;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            // explicit wrap so non-power-of-two N never indexes past N-1
            j = int'(start) + k;
            if (j >= N) j = j - N;
            cand = PW'(j);
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/cgra_regfile_arbiter.sv
// Shares a 1-write / 2-read CGRA register file between NUM_REQ requesters.
//   CGRA_Clock, CGRA_Reset       : clock, async active-high reset
//   arb_enable                   : 0 freezes all grants and pointers
//   wr_valid/wr_ready/addr/data  : per-requester write channel (round-robin)
//   rd_valid/rd_ready/rd_addr    : per-requester read channel (two grants/cycle)
//   rd_resp_valid/rd_resp_data   : read result, one cycle after the grant
//   rf_*                         : register-file pins (WE0, address_in0, in0,
//                                  address_out0/1, out0/1)
module cgra_regfile_arbiter
    import cgra_rf_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int LOG2REGS = 1,
    parameter int SIZE     = 32
) (
    input  logic                         CGRA_Clock,
    input  logic                         CGRA_Reset,
    input  logic                         arb_enable,
    input  logic [NUM_REQ-1:0]           wr_valid,
    output logic [NUM_REQ-1:0]           wr_ready,
    input  logic [NUM_REQ*LOG2REGS-1:0]  wr_addr,
    input  logic [NUM_REQ*SIZE-1:0]      wr_data,
    input  logic [NUM_REQ-1:0]           rd_valid,
    output logic [NUM_REQ-1:0]           rd_ready,
    input  logic [NUM_REQ*LOG2REGS-1:0]  rd_addr,
    output logic [NUM_REQ-1:0]           rd_resp_valid,
    output logic [NUM_REQ*SIZE-1:0]      rd_resp_data,
    output logic                         rf_we,
    output logic [LOG2REGS-1:0]          rf_waddr,
    output logic [SIZE-1:0]              rf_wdata,
    output logic [LOG2REGS-1:0]          rf_raddr0,
    output logic [LOG2REGS-1:0]          rf_raddr1,
    input  logic [SIZE-1:0]              rf_rdata0,
    input  logic [SIZE-1:0]              rf_rdata1
);
    localparam int PW = ptr_width(NUM_REQ);

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (int'(p) == NUM_REQ - 1) ? '0 : p + PW'(1);
    endfunction

    logic [PW-1:0] wr_ptr, rd_ptr;
    resp_tag_t     tag0, tag1;

    // Reset and freeze both suppress every request before arbitration, so
    // grants, rf_we and pointer updates all fall away together.
    logic               grant_en;
    logic [NUM_REQ-1:0] wr_req, rd_req;
    assign grant_en = arb_enable & ~CGRA_Reset;
    assign wr_req   = wr_valid & {NUM_REQ{grant_en}};
    assign rd_req   = rd_valid & {NUM_REQ{grant_en}};

    logic          wr_found, rd0_found, rd1_found;
    logic [PW-1:0] wr_idx, rd0_idx, rd1_idx;
    logic [NUM_REQ-1:0] wr_oh, rd0_oh, rd1_oh;

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_wr_pick (
        .req(wr_req), .start(wr_ptr), .mask('0), .found(wr_found), .idx(wr_idx)
    );

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_rd0_pick (
        .req(rd_req), .start(rd_ptr), .mask('0), .found(rd0_found), .idx(rd0_idx)
    );

    // Second read search resumes after g0 with g0 masked; requesters between
    // rd_ptr and g0 are known idle, so a full wrap equals stopping at rd_ptr.
    rr_pick #(.N(NUM_REQ), .PW(PW)) u_rd1_pick (
        .req(rd_req), .start(wrap_inc(rd0_idx)), .mask(rd0_found ? rd0_oh : '0),
        .found(rd1_found), .idx(rd1_idx)
    );

    assign wr_oh  = NUM_REQ'(1) << wr_idx;
    assign rd0_oh = NUM_REQ'(1) << rd0_idx;
    assign rd1_oh = NUM_REQ'(1) << rd1_idx;

    assign wr_ready  = wr_found ? wr_oh : '0;
    assign rf_we     = wr_found;
    assign rf_waddr  = wr_found ? wr_addr[wr_idx*LOG2REGS +: LOG2REGS] : '0;
    assign rf_wdata  = wr_found ? wr_data[wr_idx*SIZE +: SIZE] : '0;

    assign rd_ready  = (rd0_found ? rd0_oh : '0) | (rd1_found ? rd1_oh : '0);
    assign rf_raddr0 = rd0_found ? rd_addr[rd0_idx*LOG2REGS +: LOG2REGS] : '0;
    assign rf_raddr1 = rd1_found ? rd_addr[rd1_idx*LOG2REGS +: LOG2REGS] : '0;

    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
        if (CGRA_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            tag0   <= '0;
            tag1   <= '0;
        end else begin
            if (wr_found) wr_ptr <= wrap_inc(wr_idx);
            if (rd1_found)      rd_ptr <= wrap_inc(rd1_idx);
            else if (rd0_found) rd_ptr <= wrap_inc(rd0_idx);
            tag0.valid <= rd0_found;
            tag0.id    <= TAG_ID_W'(rd0_idx);
            tag1.valid <= rd1_found;
            tag1.id    <= TAG_ID_W'(rd1_idx);
        end
    end

    // The RF registers its read, so the tags line up with out0/out1 now.
    logic [PW-1:0] id0, id1;
    assign id0 = PW'(tag0.id);
    assign id1 = PW'(tag1.id);

    always_comb begin
        rd_resp_valid = '0;
        rd_resp_data  = '0;
        if (!CGRA_Reset && tag0.valid) begin
            rd_resp_valid[id0]              = 1'b1;
            rd_resp_data[id0*SIZE +: SIZE]  = rf_rdata0;
        end
        if (!CGRA_Reset && tag1.valid) begin
            rd_resp_valid[id1]              = 1'b1;
            rd_resp_data[id1*SIZE +: SIZE]  = rf_rdata1;
        end
    end
endmodule
